// File: rtl/wbf_rd_arb_pkg.sv
// rtl/wbf_rd_arb_pkg.sv - shared states, priority modes and tag width helper for the read arbiter
package wbf_rd_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WORK  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic PRIO_RR  = 1'b0;
   localparam logic PRIO_FIX = 1'b1;

   function automatic int tag_width(input int num_port);
      return (num_port > 1) ? $clog2(num_port) : 1;
   endfunction

endpackage

// File: rtl/wbf_rd_arb_if.sv
// rtl/wbf_rd_arb_if.sv - config, WCA and Weight Buffer signals; WBF_RD_ARB_PERF_EN adds the perf counters
interface wbf_rd_arb_if #(
   parameter int NUM_PORT       = 4,
   parameter int WEI_ADDR_WIDTH = 8,
   parameter int DATA_WIDTH     = 8,
   parameter int ISA_WIDTH      = NUM_PORT + 1
);
   logic                               TOPWBA_CfgVld;
   logic [ISA_WIDTH-1:0]               TOPWBA_CfgISA;
   logic                               WBATOP_CfgRdy;
   logic [NUM_PORT-1:0]                WCAWBA_AdrVld;
   logic [NUM_PORT*WEI_ADDR_WIDTH-1:0] WCAWBA_Adr;
   logic [NUM_PORT-1:0]                WBAWCA_AdrRdy;
   logic [NUM_PORT-1:0]                WBAWCA_DatVld;
   logic [NUM_PORT*DATA_WIDTH-1:0]     WBAWCA_Dat;
   logic [NUM_PORT-1:0]                WCAWBA_DatRdy;
   logic                               WBAWBF_AdrVld;
   logic [WEI_ADDR_WIDTH-1:0]          WBAWBF_Adr;
   logic                               WBFWBA_AdrRdy;
   logic                               WBFWBA_DatVld;
   logic [DATA_WIDTH-1:0]              WBFWBA_Dat;
   logic                               WBAWBF_DatRdy;
   logic                               WBATOP_Err;
`ifdef WBF_RD_ARB_PERF_EN
   logic [NUM_PORT*16-1:0]             WBATOP_PerfCnt;
`endif

   modport slave (
      input  TOPWBA_CfgVld, TOPWBA_CfgISA, WCAWBA_AdrVld, WCAWBA_Adr, WCAWBA_DatRdy,
             WBFWBA_AdrRdy, WBFWBA_DatVld, WBFWBA_Dat,
      output WBATOP_CfgRdy, WBAWCA_AdrRdy, WBAWCA_DatVld, WBAWCA_Dat,
             WBAWBF_AdrVld, WBAWBF_Adr, WBAWBF_DatRdy, WBATOP_Err
`ifdef WBF_RD_ARB_PERF_EN
      , output WBATOP_PerfCnt
`endif
   );

   modport master (
      output TOPWBA_CfgVld, TOPWBA_CfgISA, WCAWBA_AdrVld, WCAWBA_Adr, WCAWBA_DatRdy,
             WBFWBA_AdrRdy, WBFWBA_DatVld, WBFWBA_Dat,
      input  WBATOP_CfgRdy, WBAWCA_AdrRdy, WBAWCA_DatVld, WBAWCA_Dat,
             WBAWBF_AdrVld, WBAWBF_Adr, WBAWBF_DatRdy, WBATOP_Err
`ifdef WBF_RD_ARB_PERF_EN
      , input WBATOP_PerfCnt
`endif
   );
endinterface

// File: rtl/wbf_rd_arb_tag_fifo.sv
// rtl/wbf_rd_arb_tag_fifo.sv - in-order FIFO of granted port tags (DEPTH must be a power of 2)
module tag_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push & ~do_pop)      count <= count + 1'b1;
         else if (~do_push & do_pop) count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/wbf_rd_arb.sv
// rtl/wbf_rd_arb.sv - shares the Weight Buffer read port among NUM_PORT Weight Caches
// WBF_RD_ARB_PERF_EN adds per-port stall counters on WBATOP_PerfCnt.
module wbf_rd_arb
   import wbf_rd_arb_pkg::*;
#(
   parameter int NUM_PORT       = 4,
   parameter int WEI_ADDR_WIDTH = 8,
   parameter int DATA_WIDTH     = 8,
   parameter int OUT_DEPTH      = 4,
   parameter int ISA_WIDTH      = NUM_PORT + 1
) (
   input logic          clk,
   input logic          rst,
   wbf_rd_arb_if.slave  bus
);
   localparam int TW = tag_width(NUM_PORT);

   state_t               state;
   logic                 cfg_rdy;
   logic                 err;
   logic [ISA_WIDTH-1:0] cfg;
   logic [NUM_PORT-1:0]  port_mask;
   logic                 prio_mode;
   logic [TW-1:0]        rr_ptr;
   logic [TW-1:0]        lock_port;
   logic                 lock_vld;
   logic [TW-1:0]        grant;
   logic [TW-1:0]        idx;
   logic                 found;
   logic [TW-1:0]        head;
   logic [NUM_PORT-1:0]  req;
   logic                 adr_vld;
   logic                 adr_hs;
   logic                 dat_hs;
   logic                 fifo_full;
   logic                 fifo_empty;

   assign port_mask = cfg[ISA_WIDTH-1:1];
   assign prio_mode = cfg[0];
   assign req       = bus.WCAWBA_AdrVld & port_mask;

   // A stalled grant stays locked so the address presented downstream cannot change.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      if (lock_vld && req[lock_port]) begin
         grant = lock_port;
      end else if (prio_mode == PRIO_FIX) begin
         for (int i = NUM_PORT - 1; i >= 0; i--) begin
            if (req[i]) grant = TW'(i);
         end
      end else begin
         for (int i = 0; i < NUM_PORT; i++) begin
            idx = TW'((int'(rr_ptr) + i) % NUM_PORT);
            if (!found && req[idx]) begin
               grant = idx;
               found = 1'b1;
            end
         end
      end
   end

   assign adr_vld = (state == WORK) & (|req) & ~fifo_full;
   assign adr_hs  = adr_vld & bus.WBFWBA_AdrRdy;

   assign bus.WBAWBF_AdrVld = adr_vld;
   assign bus.WBAWBF_Adr    = bus.WCAWBA_Adr[int'(grant)*WEI_ADDR_WIDTH +: WEI_ADDR_WIDTH];

   always_comb begin
      bus.WBAWCA_AdrRdy        = '0;
      bus.WBAWCA_AdrRdy[grant] = adr_hs;
      bus.WBAWCA_DatVld        = '0;
      bus.WBAWCA_DatVld[head]  = bus.WBFWBA_DatVld & ~fifo_empty;
   end

   assign bus.WBAWBF_DatRdy = bus.WCAWBA_DatRdy[head] & ~fifo_empty;
   assign bus.WBAWCA_Dat    = fifo_empty ? '0 : {NUM_PORT{bus.WBFWBA_Dat}};
   assign dat_hs            = bus.WBFWBA_DatVld & bus.WBAWBF_DatRdy;
   assign bus.WBATOP_CfgRdy = cfg_rdy;
   assign bus.WBATOP_Err    = err;

   tag_fifo #(.WIDTH(TW), .DEPTH(OUT_DEPTH)) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (adr_hs),
      .din   (grant),
      .pop   (dat_hs),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cfg_rdy   <= 1'b1;
         cfg       <= '0;
         rr_ptr    <= '0;
         lock_vld  <= 1'b0;
         lock_port <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.TOPWBA_CfgVld && cfg_rdy) begin
               cfg     <= bus.TOPWBA_CfgISA;
               state   <= WORK;
               cfg_rdy <= 1'b0;
            end
            WORK: if (bus.TOPWBA_CfgVld) state <= DRAIN;
            DRAIN: if (fifo_empty && !dat_hs) begin
               state   <= IDLE;
               cfg_rdy <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               cfg_rdy <= 1'b1;
            end
         endcase

         if (adr_hs) begin
            lock_vld <= 1'b0;
            if (prio_mode == PRIO_RR)
               rr_ptr <= (grant == TW'(NUM_PORT - 1)) ? '0 : grant + 1'b1;
         end else if (adr_vld) begin
            lock_vld  <= 1'b1;
            lock_port <= grant;
         end else if (state != WORK) begin
            lock_vld <= 1'b0;
         end

         // Data with nothing outstanding cannot be steered anywhere.
         if (bus.WBFWBA_DatVld && fifo_empty) err <= 1'b1;
      end
   end

`ifdef WBF_RD_ARB_PERF_EN
   logic [15:0] perf_cnt [NUM_PORT];

   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORT; p++) begin
         if (rst || (state == IDLE && bus.TOPWBA_CfgVld && cfg_rdy))
            perf_cnt[p] <= '0;
         else if (state == WORK && req[p] && !(adr_hs && grant == TW'(p)) && perf_cnt[p] != 16'hFFFF)
            perf_cnt[p] <= perf_cnt[p] + 16'd1;
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_PORT; p++) bus.WBATOP_PerfCnt[p*16 +: 16] = perf_cnt[p];
   end
`endif
endmodule
